// File: rtl/vga_img_sender_if.sv
// vga_img_sender_if
//   Bundles the frame-sender's control, RAM read port and serial output.
//   master : the sender (drives rd_addr/rd_en/tx/busy/done, samples start/rd_data)
//   slave  : the surrounding system (drives start and RAM read data)
//   Signals:
//     start    1-cycle request to send one frame
//     rd_data  RAM read data {R[2:0],G[2:0],B[2:0]}, valid one cycle after rd_en
//     rd_addr  RAM read address
//     rd_en    RAM read strobe
//     tx       UART serial line, idle high
//     busy     frame in progress
//     done     1-cycle pulse once the frame has been sent
interface vga_img_sender_if #(
  parameter int addr_w = 15
) ();
  logic              start;
  logic [8:0]        rd_data;
  logic [addr_w-1:0] rd_addr;
  logic              rd_en;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    input  start, rd_data,
    output rd_addr, rd_en, tx, busy, done
  );

  modport slave (
    output start, rd_data,
    input  rd_addr, rd_en, tx, busy, done
  );
endinterface

// File: rtl/vga_img_sender.sv
// vga_img_sender
//   Streams the RGB333 frame buffer to a host over UART 8N1. Each pixel goes
//   out as two back-to-back characters: rd_data[7:0], then {7'b0, rd_data[8]},
//   LSB first, with no idle time between characters or pixels. The next pixel
//   is prefetched while the high byte of the current one is on the line.
//   Ports:
//     clk_in  system clock
//     reset   synchronous reset, active-low
//     bus     vga_img_sender_if master: start, rd_data in; rd_addr, rd_en,
//             tx, busy, done out
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line idle, waiting for start
//   FETCH   | read strobe for pixel 0 is on the RAM port
//   LOAD    | pixel 0 data valid; capture it and drive the first start bit
//   SEND_LO | shifting out the low byte of the current pixel
//   SEND_HI | shifting out the high byte; next pixel fetched in parallel
//   FINISH  | done pulse, busy dropped
module vga_img_sender #(
  parameter int clk_freq = 12000000,
  parameter int baud     = 115200,
  parameter int n_pixels = 19200,
  parameter int addr_w   = 15
) (
  input  logic             clk_in,
  input  logic             reset,
  vga_img_sender_if.master bus
);

  localparam int BAUD_DIV = clk_freq / baud;
  localparam int BCW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BCW-1:0]    BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [addr_w-1:0] LAST_IDX  = addr_w'(n_pixels - 1);
  localparam logic [addr_w-1:0] IDX_ONE   = addr_w'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND_LO,
    SEND_HI,
    FINISH
  } state_t;

  state_t            state_q;
  logic [BCW-1:0]    baud_cnt_q;
  logic [3:0]        bit_idx_q;
  logic [addr_w-1:0] pixel_idx_q;
  logic [addr_w-1:0] rd_addr_q;
  logic [8:0]        pix_q;
  logic [8:0]        hold_q;
  logic              rd_en_q;
  logic              cap_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0] cur_byte_d;
  logic       tx_next_d;
  logic       bit_end_d;
  logic       more_d;

  // bit_idx 0 is the start bit, 1..8 data, 9 stop. tx_next_d is the line
  // level for bit_idx+1, driven at the edge that ends the current bit so the
  // registered tx lines up with the counters.
  always_comb begin
    cur_byte_d = (state_q == SEND_HI) ? {7'b0, pix_q[8]} : pix_q[7:0];
    tx_next_d  = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte_d[bit_idx_q[2:0]];
    bit_end_d  = (baud_cnt_q == BAUD_LAST);
    more_d     = (pixel_idx_q != LAST_IDX);
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      pixel_idx_q <= '0;
      rd_addr_q   <= '0;
      pix_q       <= '0;
      hold_q      <= '0;
      rd_en_q     <= 1'b0;
      cap_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // RAM data is valid the cycle after a strobe; park it in the holding
      // register so it survives until the current pixel has been sent.
      cap_q <= rd_en_q;
      if (cap_q) begin
        hold_q <= bus.rd_data;
      end
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= FETCH;
            busy_q      <= 1'b1;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= '0;
            pixel_idx_q <= '0;
          end
        end

        FETCH: begin
          state_q <= LOAD;
        end

        LOAD: begin
          pix_q      <= bus.rd_data;
          state_q    <= SEND_LO;
          tx_q       <= 1'b0;
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
        end

        SEND_LO, SEND_HI: begin
          if (!bit_end_d) begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end else begin
            baud_cnt_q <= '0;
            if (bit_idx_q != 4'd9) begin
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= tx_next_d;
            end else if (state_q == SEND_LO) begin
              state_q   <= SEND_HI;
              bit_idx_q <= '0;
              tx_q      <= 1'b0;
              // Strobe lands in the first cycle of SEND_HI.
              if (more_d) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= pixel_idx_q + IDX_ONE;
              end
            end else if (more_d) begin
              pix_q       <= hold_q;
              pixel_idx_q <= pixel_idx_q + IDX_ONE;
              state_q     <= SEND_LO;
              bit_idx_q   <= '0;
              tx_q        <= 1'b0;
            end else begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end
          end
        end

        FINISH: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
